turn_receive_handler: RTL and testbench

TURN_RECEIVE_HANDLER -- requirements
Module: turn_receive_handler

---
 rtl/turn_receive_handler_if.sv | 52 +++++
 rtl/turn_receive_handler.sv | 136 +++++++++++++
 tb/tb_turn_receive_handler.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/turn_receive_handler_if.sv
// ============================================================================
// Module  : turn_receive_handler_if
// Purpose : Message/handshake bundle between the turn receive handler and its
//           surroundings: received interboard fields, transmitter ready, the
//           local end-of-turn pulse, turn status and the acknowledge request.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface turn_receive_handler_if;
  // received interboard message
  logic       interboard_en;
  logic [3:0] interboard_msg_type;
  logic       interboard_move_dir;
  // transmitter flow control and local game events
  logic       inter_ready;
  logic       local_switch_turn;
  // turn status
  logic       my_turn;
  logic       turn_start;
  logic       opp_drew;
  logic [7:0] turn_count;
  logic       protocol_err;
  // acknowledge message towards the transmitter
  logic       ack_ctrl_en;
  logic [3:0] ack_ctrl_msg_type;
  logic       ack_ctrl_move_dir;
  logic [4:0] ack_ctrl_block_x;
  logic [2:0] ack_ctrl_block_y;
  logic [5:0] ack_ctrl_card;
  logic [2:0] ack_ctrl_sel_len;

  // handler side
  modport slave (
    input  interboard_en, interboard_msg_type, interboard_move_dir,
    input  inter_ready, local_switch_turn,
    output my_turn, turn_start, opp_drew, turn_count, protocol_err,
    output ack_ctrl_en, ack_ctrl_msg_type, ack_ctrl_move_dir,
    output ack_ctrl_block_x, ack_ctrl_block_y, ack_ctrl_card, ack_ctrl_sel_len
  );

  // environment side
  modport master (
    output interboard_en, interboard_msg_type, interboard_move_dir,
    output inter_ready, local_switch_turn,
    input  my_turn, turn_start, opp_drew, turn_count, protocol_err,
    input  ack_ctrl_en, ack_ctrl_msg_type, ack_ctrl_move_dir,
    input  ack_ctrl_block_x, ack_ctrl_block_y, ack_ctrl_card, ack_ctrl_sel_len
  );
endinterface

`default_nettype wire

// File: rtl/turn_receive_handler.sv
// ============================================================================
// Module  : turn_receive_handler
// Purpose : Tracks which board holds the turn. Accepts the opponent's
//           "switch turn" message, acknowledges it once the transmitter is
//           ready, counts completed local turns and flags protocol errors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module turn_receive_handler #(
  parameter int         PLAYER          = 0,
  parameter logic [3:0] MSG_SWITCH_TURN = 4'd5,
  parameter logic [3:0] MSG_TURN_ACK    = 4'd6,
  parameter int         ACK_TIMEOUT     = 1000
) (
  input  logic                  clk,
  input  logic                  rst,            // synchronous, active-low
  input  logic                  interboard_rst, // synchronous, active-high
  turn_receive_handler_if.slave bus
);

  typedef enum logic [1:0] {
    OPP_TURN = 2'd0,
    ACK_WAIT = 2'd1,
    MY_TURN  = 2'd2
  } state_t;

  // board 0 owns the first turn
  localparam state_t     RESET_STATE   = (PLAYER == 0) ? MY_TURN : OPP_TURN;
  localparam logic [9:0] TIMEOUT_LIMIT = 10'(ACK_TIMEOUT);

  state_t     state_q, state_d;
  logic [9:0] ack_cnt_q, ack_cnt_d;
  logic [7:0] turn_count_q, turn_count_d;
  logic       opp_drew_q, opp_drew_d;
  logic       protocol_err_q, protocol_err_d;
  logic       turn_start_q, turn_start_d;
  logic       ack_en_q, ack_en_d;
  logic       switch_msg;

  assign switch_msg = bus.interboard_en && (bus.interboard_msg_type == MSG_SWITCH_TURN);

  // Next-state and next-output decode; every register holds unless a rule fires.
  always_comb begin
    state_d        = state_q;
    ack_cnt_d      = ack_cnt_q;
    turn_count_d   = turn_count_q;
    opp_drew_d     = opp_drew_q;
    protocol_err_d = protocol_err_q;
    turn_start_d   = 1'b0;
    ack_en_d       = 1'b0;

    case (state_q)
      OPP_TURN: begin
        // only a switch message matters here; local end-of-turn is ignored
        if (switch_msg) begin
          opp_drew_d = bus.interboard_move_dir;
          ack_cnt_d  = 10'd0;
          state_d    = ACK_WAIT;
        end
      end

      ACK_WAIT: begin
        // a second switch while already handshaking is an error, not a restart
        if (switch_msg) begin
          protocol_err_d = 1'b1;
        end
        if (bus.inter_ready) begin
          state_d      = MY_TURN;
          ack_en_d     = 1'b1;
          turn_start_d = 1'b1;
        end else begin
          // saturate so a long stall cannot wrap the counter
          if (ack_cnt_q != TIMEOUT_LIMIT) begin
            ack_cnt_d = ack_cnt_q + 10'd1;
          end
          if (ack_cnt_d == TIMEOUT_LIMIT) begin
            protocol_err_d = 1'b1;
          end
        end
      end

      MY_TURN: begin
        // opponent cannot end a turn it does not hold; the message is dropped
        if (switch_msg) begin
          protocol_err_d = 1'b1;
        end
        if (bus.local_switch_turn) begin
          state_d      = OPP_TURN;
          turn_count_d = turn_count_q + 8'd1;
        end
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // State and output registers; either reset source overrides all other inputs.
  always_ff @(posedge clk) begin
    if (!rst || interboard_rst) begin
      state_q        <= RESET_STATE;
      ack_cnt_q      <= 10'd0;
      turn_count_q   <= 8'd0;
      opp_drew_q     <= 1'b0;
      protocol_err_q <= 1'b0;
      turn_start_q   <= 1'b0;
      ack_en_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      ack_cnt_q      <= ack_cnt_d;
      turn_count_q   <= turn_count_d;
      opp_drew_q     <= opp_drew_d;
      protocol_err_q <= protocol_err_d;
      turn_start_q   <= turn_start_d;
      ack_en_q       <= ack_en_d;
    end
  end

  assign bus.my_turn           = (state_q == MY_TURN);
  assign bus.turn_start        = turn_start_q;
  assign bus.opp_drew          = opp_drew_q;
  assign bus.turn_count        = turn_count_q;
  assign bus.protocol_err      = protocol_err_q;
  assign bus.ack_ctrl_en       = ack_en_q;
  assign bus.ack_ctrl_msg_type = MSG_TURN_ACK;
  assign bus.ack_ctrl_move_dir = 1'b0;
  assign bus.ack_ctrl_block_x  = 5'd0;
  assign bus.ack_ctrl_block_y  = 3'd0;
  assign bus.ack_ctrl_card     = 6'd0;
  assign bus.ack_ctrl_sel_len  = 3'd0;

endmodule

`default_nettype wire

// File: tb/tb_turn_receive_handler.sv
// ============================================================================
// Module  : tb_turn_receive_handler
// Purpose : Self-checking bench for turn_receive_handler. Two instances
//           (PLAYER 0 and PLAYER 1) share one stimulus stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_turn_receive_handler;

  localparam int TO = 40;

  logic       clk;
  logic       rst_n;
  logic       irst;
  logic       en;
  logic [3:0] mtype;
  logic       dir;
  logic       ready;
  logic       local_sw;

  int checks;
  int passed;

  turn_receive_handler_if b0 ();
  turn_receive_handler_if b1 ();

  assign b0.interboard_en       = en;
  assign b0.interboard_msg_type = mtype;
  assign b0.interboard_move_dir = dir;
  assign b0.inter_ready         = ready;
  assign b0.local_switch_turn   = local_sw;
  assign b1.interboard_en       = en;
  assign b1.interboard_msg_type = mtype;
  assign b1.interboard_move_dir = dir;
  assign b1.inter_ready         = ready;
  assign b1.local_switch_turn   = local_sw;

  turn_receive_handler #(.PLAYER(0), .ACK_TIMEOUT(TO)) dut0 (
    .clk(clk), .rst(rst_n), .interboard_rst(irst), .bus(b0)
  );
  turn_receive_handler #(.PLAYER(1), .ACK_TIMEOUT(TO)) dut1 (
    .clk(clk), .rst(rst_n), .interboard_rst(irst), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who holds the turn, whether an ack is owed and how long
  // it has been stalled, per board.
  bit m_mine[2];
  bit m_owed[2];
  int m_stall[2];
  bit m_drew[2];
  int m_turns[2];
  bit m_err[2];
  bit m_start[2];
  bit m_ack[2];

  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      m_start[p] = 1'b0;
      m_ack[p]   = 1'b0;
      if (!rst_n || irst) begin
        m_mine[p]  = (p == 0);
        m_owed[p]  = 1'b0;
        m_stall[p] = 0;
        m_drew[p]  = 1'b0;
        m_turns[p] = 0;
        m_err[p]   = 1'b0;
      end else if (m_mine[p]) begin
        if (en && mtype == 4'd5) m_err[p] = 1'b1;
        if (local_sw) begin
          m_mine[p]  = 1'b0;
          m_turns[p] = (m_turns[p] + 1) % 256;
        end
      end else if (m_owed[p]) begin
        if (en && mtype == 4'd5) m_err[p] = 1'b1;
        if (ready) begin
          m_owed[p]  = 1'b0;
          m_mine[p]  = 1'b1;
          m_start[p] = 1'b1;
          m_ack[p]   = 1'b1;
        end else begin
          if (m_stall[p] < TO) m_stall[p] = m_stall[p] + 1;
          if (m_stall[p] >= TO) m_err[p] = 1'b1;
        end
      end else if (en && mtype == 4'd5) begin
        m_drew[p]  = dir;
        m_owed[p]  = 1'b1;
        m_stall[p] = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en = 1'b0; mtype = 4'd0; dir = 1'b0; ready = 1'b0; local_sw = 1'b0; irst = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (b0.my_turn !== 1'b1) $display("FAIL reset_p0_my_turn: got %b want 1", b0.my_turn); else passed++;
    checks++; if (b1.my_turn !== 1'b0) $display("FAIL reset_p1_my_turn: got %b want 0", b1.my_turn); else passed++;
    checks++; if ({b1.turn_count, b1.opp_drew, b1.protocol_err, b1.turn_start, b1.ack_ctrl_en} !== 12'd0)
      $display("FAIL reset_p1_outputs: got %h want 000", {b1.turn_count, b1.opp_drew, b1.protocol_err, b1.turn_start, b1.ack_ctrl_en}); else passed++;
    checks++; if ({b0.turn_count, b0.opp_drew, b0.protocol_err, b0.turn_start, b0.ack_ctrl_en} !== 12'd0)
      $display("FAIL reset_p0_outputs: got %h want 000", {b0.turn_count, b0.opp_drew, b0.protocol_err, b0.turn_start, b0.ack_ctrl_en}); else passed++;
    checks++; if ({b1.ack_ctrl_msg_type, b1.ack_ctrl_move_dir, b1.ack_ctrl_block_x, b1.ack_ctrl_block_y,
                   b1.ack_ctrl_card, b1.ack_ctrl_sel_len} !== {4'd6, 18'd0})
      $display("FAIL reset_ack_constants: got type %0d want 6", b1.ack_ctrl_msg_type); else passed++;
  endtask

  task automatic test_switch_accept();
    do_reset();
    ready = 1'b1; en = 1'b1; mtype = 4'd5; dir = 1'b1;
    step();
    en = 1'b0; dir = 1'b0;
    checks++; if (b1.ack_ctrl_en !== 1'b0 || b1.my_turn !== 1'b0)
      $display("FAIL accept_early: got ack %b my_turn %b want 0 0", b1.ack_ctrl_en, b1.my_turn); else passed++;
    step();
    checks++; if ({b1.ack_ctrl_en, b1.turn_start, b1.my_turn, b1.opp_drew} !== 4'b1111)
      $display("FAIL accept_ack: got ack/start/my/drew %b want 1111", {b1.ack_ctrl_en, b1.turn_start, b1.my_turn, b1.opp_drew}); else passed++;
    checks++; if (b1.ack_ctrl_msg_type !== 4'd6) $display("FAIL accept_msg_type: got %0d want 6", b1.ack_ctrl_msg_type); else passed++;
    step();
    checks++; if ({b1.ack_ctrl_en, b1.turn_start, b1.my_turn} !== 3'b001)
      $display("FAIL accept_pulse_width: got ack/start/my %b want 001", {b1.ack_ctrl_en, b1.turn_start, b1.my_turn}); else passed++;
    checks++; if (b1.protocol_err !== 1'b0) $display("FAIL accept_err: got %b want 0", b1.protocol_err); else passed++;
  endtask

  task automatic test_ignored_types();
    do_reset();
    ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      if (t != 5) begin
        en = 1'b1; mtype = 4'(t); dir = 1'b1;
        step();
        checks++; if ({b1.my_turn, b1.turn_start, b1.ack_ctrl_en, b1.opp_drew, b1.protocol_err, b1.turn_count} !== 13'd0)
          $display("FAIL ignored_type_%0d: got %h want 0000", t,
                   {b1.my_turn, b1.turn_start, b1.ack_ctrl_en, b1.opp_drew, b1.protocol_err, b1.turn_count}); else passed++;
      end
    end
    en = 1'b0;
    step();
    step();
    checks++; if ({b1.my_turn, b1.ack_ctrl_en} !== 2'b00)
      $display("FAIL ignored_settle: got my/ack %b want 00", {b1.my_turn, b1.ack_ctrl_en}); else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    en = 1'b1; mtype = 4'd5; dir = 1'b0;
    step();
    en = 1'b0;
    for (int i = 0; i < TO - 1; i++) step();
    checks++; if (b1.protocol_err !== 1'b0) $display("FAIL timeout_early: got %b want 0", b1.protocol_err); else passed++;
    step();
    checks++; if ({b1.protocol_err, b1.ack_ctrl_en, b1.my_turn} !== 3'b100)
      $display("FAIL timeout_flag: got err/ack/my %b want 100", {b1.protocol_err, b1.ack_ctrl_en, b1.my_turn}); else passed++;
    for (int i = 0; i < 10; i++) step();
    checks++; if ({b1.protocol_err, b1.ack_ctrl_en} !== 2'b10)
      $display("FAIL timeout_still_waiting: got err/ack %b want 10", {b1.protocol_err, b1.ack_ctrl_en}); else passed++;
    ready = 1'b1;
    step();
    checks++; if ({b1.ack_ctrl_en, b1.turn_start, b1.my_turn, b1.protocol_err} !== 4'b1111)
      $display("FAIL timeout_late_ack: got ack/start/my/err %b want 1111", {b1.ack_ctrl_en, b1.turn_start, b1.my_turn, b1.protocol_err}); else passed++;
  endtask

  task automatic test_collision();
    do_reset();
    local_sw = 1'b1; en = 1'b1; mtype = 4'd5; dir = 1'b1;
    step();
    local_sw = 1'b0; en = 1'b0; dir = 1'b0;
    checks++; if ({b0.my_turn, b0.protocol_err, b0.turn_count} !== {1'b0, 1'b1, 8'd1})
      $display("FAIL collision: got my/err/count %b/%b/%0d want 0/1/1", b0.my_turn, b0.protocol_err, b0.turn_count); else passed++;
    ready = 1'b1;
    step();
    step();
    checks++; if ({b0.my_turn, b0.ack_ctrl_en, b0.opp_drew} !== 3'b000)
      $display("FAIL collision_dropped: got my/ack/drew %b want 000", {b0.my_turn, b0.ack_ctrl_en, b0.opp_drew}); else passed++;
  endtask

  task automatic test_abort();
    do_reset();
    en = 1'b1; mtype = 4'd5; dir = 1'b1;
    step();
    en = 1'b0;
    step(); step(); step();
    ready = 1'b1; irst = 1'b1;
    step();
    irst = 1'b0;
    checks++; if ({b1.my_turn, b1.ack_ctrl_en, b1.turn_start, b1.opp_drew, b1.protocol_err, b1.turn_count} !== 13'd0)
      $display("FAIL interboard_rst_abort: got %h want 0000", {b1.my_turn, b1.ack_ctrl_en, b1.turn_start, b1.opp_drew, b1.protocol_err, b1.turn_count}); else passed++;
    step();
    checks++; if ({b1.my_turn, b1.ack_ctrl_en} !== 2'b00)
      $display("FAIL interboard_rst_no_ack: got my/ack %b want 00", {b1.my_turn, b1.ack_ctrl_en}); else passed++;
    ready = 1'b0; en = 1'b1;
    step();
    en = 1'b0;
    step();
    rst_n = 1'b0; ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    checks++; if ({b1.my_turn, b1.ack_ctrl_en, b1.turn_start} !== 3'b000)
      $display("FAIL rst_abort: got my/ack/start %b want 000", {b1.my_turn, b1.ack_ctrl_en, b1.turn_start}); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    ready = 1'b1; mtype = 4'd5;
    for (int i = 0; i < 256; i++) begin
      local_sw = 1'b1;
      step();
      local_sw = 1'b0; en = 1'b1; dir = 1'(i);
      step();
      en = 1'b0;
      step();
      if (i == 254) begin
        checks++; if (b0.turn_count !== 8'd255) $display("FAIL wrap_255: got %0d want 255", b0.turn_count); else passed++;
      end
    end
    checks++; if ({b0.turn_count, b0.protocol_err, b0.my_turn} !== {8'd0, 1'b0, 1'b1})
      $display("FAIL wrap_zero: got count/err/my %0d/%b/%b want 0/0/1", b0.turn_count, b0.protocol_err, b0.my_turn); else passed++;
  endtask

  task automatic test_random();
    bit stall;
    logic [15:0] got;
    logic [15:0] want;
    int errs;
    stall = 1'b0;
    errs  = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(59, 0) == 0) stall = ~stall;
      en       = ($urandom_range(3, 0) == 0);
      mtype    = ($urandom_range(1, 0) == 0) ? 4'd5 : 4'($urandom_range(15, 0));
      dir      = 1'($urandom_range(1, 0));
      ready    = !stall && ($urandom_range(3, 0) != 0);
      local_sw = ($urandom_range(3, 0) == 0);
      irst     = ($urandom_range(299, 0) == 0);
      rst_n    = ($urandom_range(399, 0) != 0);
      step();
      for (int p = 0; p < 2; p++) begin
        if (p == 0) got = {3'd0, b0.my_turn, b0.turn_start, b0.opp_drew, b0.protocol_err, b0.ack_ctrl_en, b0.turn_count};
        else        got = {3'd0, b1.my_turn, b1.turn_start, b1.opp_drew, b1.protocol_err, b1.ack_ctrl_en, b1.turn_count};
        want = {3'd0, m_mine[p], m_start[p], m_drew[p], m_err[p], m_ack[p], 8'(m_turns[p])};
        checks++;
        if (got !== want) begin
          if (errs < 10) $display("FAIL random_p%0d_cycle%0d: got %h want %h", p, c, got, want);
          errs++;
        end else passed++;
      end
    end
    idle_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_switch_accept();
    test_ignored_types();
    test_timeout();
    test_collision();
    test_abort();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
